// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch port, the data port and the single-ported
// memory. The arbiter connects through the slave modport, and the driving
// environment connects through the master modport.
interface mem_port_arbiter_if #(
    parameter int W = 32
);
    logic         if_req;
    logic [W-1:0] if_addr;
    logic         if_valid;
    logic [W-1:0] if_rdata;
    logic         d_req;
    logic         d_we;
    logic [W-1:0] d_addr;
    logic [W-1:0] d_wdata;
    logic         d_valid;
    logic [W-1:0] d_rdata;
    logic         mem_en;
    logic         mem_we;
    logic [W-1:0] mem_addr;
    logic [W-1:0] mem_wdata;
    logic [W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_valid, if_rdata, d_valid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_valid, if_rdata, d_valid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the instruction fetch port and the data port onto one memory with
// a fixed read latency. Data normally wins, but fetch is forced through after
// STARVE_MAX consecutive denials. Only one access is in flight at a time, and
// a requester that drops its request mid-access loses the completion strobe.
module mem_port_arbiter #(
    parameter int W          = 32,
    parameter int LAT        = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mem_port_arbiter_if.slave      bus,
    output logic                   o_stall_f,
    output logic                   o_stall_m
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    localparam logic [2:0] LAT_INIT   = 3'(LAT - 1);
    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    state_t     r_state;
    logic [2:0] r_latCnt;
    logic [2:0] r_starveCnt;
    logic       r_abort;
    logic       r_isStore;

    state_t     w_nextState;
    logic       w_grantI;
    logic       w_grantD;
    logic       w_complete;
    logic       w_ownerReq;

    // State register plus latency, starvation, abort and store bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_latCnt    <= 3'd0;
            r_starveCnt <= 3'd0;
            r_abort     <= 1'b0;
            r_isStore   <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (w_grantI || w_grantD) begin
                r_latCnt  <= LAT_INIT;
                r_isStore <= w_grantD && bus.d_we;
                r_abort   <= 1'b0;
                if (w_grantI) begin
                    r_starveCnt <= 3'd0;
                end else if (bus.if_req && (r_starveCnt != STARVE_LIM)) begin
                    r_starveCnt <= r_starveCnt + 3'd1;
                end
            end else if (r_state != IDLE) begin
                if (w_complete) begin
                    r_abort <= 1'b0;
                end else begin
                    r_latCnt <= r_latCnt - 3'd1;
                    if (!w_ownerReq) begin
                        r_abort <= 1'b1;
                    end
                end
            end
        end
    end

    // Arbitration, next state, memory drive and completion outputs.
    always_comb begin
        w_nextState   = r_state;
        w_grantI      = 1'b0;
        w_grantD      = 1'b0;
        w_complete    = 1'b0;
        w_ownerReq    = 1'b0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.if_valid  = 1'b0;
        bus.if_rdata  = '0;
        bus.d_valid   = 1'b0;
        bus.d_rdata   = '0;
        o_stall_f     = 1'b0;
        o_stall_m     = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (rst_n) begin
                    if (bus.d_req && (!bus.if_req || (r_starveCnt != STARVE_LIM))) begin
                        w_grantD = 1'b1;
                    end else if (bus.if_req) begin
                        w_grantI = 1'b1;
                    end
                end
                if (w_grantD) begin
                    w_nextState   = BUSY_D;
                    bus.mem_en    = 1'b1;
                    bus.mem_we    = bus.d_we;
                    bus.mem_addr  = bus.d_addr;
                    bus.mem_wdata = bus.d_wdata;
                end else if (w_grantI) begin
                    w_nextState   = BUSY_I;
                    bus.mem_en    = 1'b1;
                    bus.mem_addr  = bus.if_addr;
                end
            end
            BUSY_I: begin
                w_ownerReq = bus.if_req;
                w_complete = (r_latCnt == 3'd0);
                if (w_complete) begin
                    w_nextState = IDLE;
                    if (!r_abort && bus.if_req) begin
                        bus.if_valid = 1'b1;
                        bus.if_rdata = bus.mem_rdata;
                    end
                end
            end
            BUSY_D: begin
                w_ownerReq = bus.d_req;
                w_complete = (r_latCnt == 3'd0);
                if (w_complete) begin
                    w_nextState = IDLE;
                    if (!r_abort && bus.d_req) begin
                        bus.d_valid = 1'b1;
                        bus.d_rdata = r_isStore ? '0 : bus.mem_rdata;
                    end
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase

        o_stall_f = rst_n && bus.if_req && !bus.if_valid;
        o_stall_m = rst_n && bus.d_req && !bus.d_valid;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with LAT=2 and STARVE_MAX=4. A table of
// per-cycle vectors covers reset, fetch, load, store, abort and reset during
// an access. A hand-written loop then holds both requests to exercise the
// starvation override.
module tb_mem_port_arbiter;

    localparam int W = 32;
    localparam int OUTW = 134;

    logic clk;
    logic rstN;
    logic stallF;
    logic stallM;

    mem_port_arbiter_if #(.W(W)) bus ();

    mem_port_arbiter #(.W(W), .LAT(2), .STARVE_MAX(4)) dut (
        .clk       (clk),
        .rst_n     (rstN),
        .bus       (bus),
        .o_stall_f (stallF),
        .o_stall_m (stallM)
    );

    typedef struct {
        logic            rstN;
        logic            ifReq;
        logic [W-1:0]    ifAddr;
        logic            dReq;
        logic            dWe;
        logic [W-1:0]    dAddr;
        logic [W-1:0]    dWdata;
        logic [W-1:0]    memRdata;
        logic [OUTW-1:0] expOut;
    } vec_t;

    vec_t vecs[$];
    int   checkCount = 0;
    int   passCount  = 0;

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pack the expected outputs in the same order as the observed bundle.
    function automatic logic [OUTW-1:0] mkExp(
        input logic en, input logic we, input logic [W-1:0] addr, input logic [W-1:0] wdata,
        input logic iv, input logic [W-1:0] ird, input logic dv, input logic [W-1:0] drd,
        input logic sf, input logic sm);
        return {en, we, addr, wdata, iv, ird, dv, drd, sf, sm};
    endfunction

    // Append one cycle's inputs and expected outputs to the vector table.
    function automatic void addVec(
        input logic rst, input logic ifReq, input logic [W-1:0] ifAddr,
        input logic dReq, input logic dWe, input logic [W-1:0] dAddr, input logic [W-1:0] dWdata,
        input logic [W-1:0] memRdata, input logic [OUTW-1:0] expOut);
        vec_t v;
        v.rstN = rst; v.ifReq = ifReq; v.ifAddr = ifAddr; v.dReq = dReq; v.dWe = dWe;
        v.dAddr = dAddr; v.dWdata = dWdata; v.memRdata = memRdata; v.expOut = expOut;
        vecs.push_back(v);
    endfunction

    // Drive one cycle's inputs.
    task automatic applyStimulus(input vec_t v);
        rstN          = v.rstN;
        bus.if_req    = v.ifReq;
        bus.if_addr   = v.ifAddr;
        bus.d_req     = v.dReq;
        bus.d_we      = v.dWe;
        bus.d_addr    = v.dAddr;
        bus.d_wdata   = v.dWdata;
        bus.mem_rdata = v.memRdata;
    endtask

    // Compare an observed value against the expected one and tally the result.
    task automatic checkOutput(input string name, input logic [OUTW-1:0] actual, input logic [OUTW-1:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    function automatic logic [OUTW-1:0] observed();
        return {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.if_valid, bus.if_rdata,
                bus.d_valid, bus.d_rdata, stallF, stallM};
    endfunction

    // Build the table, replay it cycle by cycle, then run the starvation sequence.
    initial begin
        logic [OUTW-1:0] z;
        vec_t v;
        z = '0;

        // Reset held with both requests raised: everything stays low.
        addVec(0, 1, 32'h10, 1, 0, 32'h200, 0, 0, z);
        addVec(0, 1, 32'h10, 0, 0, 0, 0, 0, z);
        // First edge after release grants the fetch; completes two cycles later.
        addVec(1, 1, 32'h10, 0, 0, 0, 0, 0, mkExp(1, 0, 32'h10, 0, 0, 0, 0, 0, 1, 0));
        addVec(1, 1, 32'h10, 0, 0, 0, 0, 0, mkExp(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        addVec(1, 1, 32'h10, 0, 0, 0, 0, 32'h00500093, mkExp(0, 0, 0, 0, 1, 32'h00500093, 0, 0, 0, 0));
        // Back-to-back fetch: next grant right after completion.
        addVec(1, 1, 32'h14, 0, 0, 0, 0, 0, mkExp(1, 0, 32'h14, 0, 0, 0, 0, 0, 1, 0));
        addVec(1, 1, 32'h14, 0, 0, 0, 0, 0, mkExp(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        addVec(1, 1, 32'h14, 0, 0, 0, 0, 32'h00000013, mkExp(0, 0, 0, 0, 1, 32'h00000013, 0, 0, 0, 0));
        // Idle: read data is not passed through.
        addVec(1, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFF, z);
        // Simultaneous requests: data first, then fetch.
        addVec(1, 1, 32'h14, 1, 0, 32'h200, 0, 0, mkExp(1, 0, 32'h200, 0, 0, 0, 0, 0, 1, 1));
        addVec(1, 1, 32'h14, 1, 0, 32'h200, 0, 0, mkExp(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        addVec(1, 1, 32'h14, 1, 0, 32'h200, 0, 32'hCAFEF00D, mkExp(0, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D, 1, 0));
        addVec(1, 1, 32'h14, 0, 0, 0, 0, 0, mkExp(1, 0, 32'h14, 0, 0, 0, 0, 0, 1, 0));
        addVec(1, 1, 32'h14, 0, 0, 0, 0, 0, mkExp(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        addVec(1, 1, 32'h14, 0, 0, 0, 0, 32'h11111111, mkExp(0, 0, 0, 0, 1, 32'h11111111, 0, 0, 0, 0));
        addVec(1, 0, 0, 0, 0, 0, 0, 0, z);
        // Store: write enable and data on the grant, zero read data on completion.
        addVec(1, 0, 0, 1, 1, 32'h100, 32'hDEADBEEF, 0, mkExp(1, 1, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1));
        addVec(1, 0, 0, 1, 1, 32'h100, 32'hDEADBEEF, 0, mkExp(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        addVec(1, 0, 0, 1, 1, 32'h100, 32'hDEADBEEF, 32'h12345678, mkExp(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        addVec(1, 0, 0, 0, 0, 0, 0, 0, z);
        // Abort: request dropped then re-raised; strobe suppressed, new address granted after.
        addVec(1, 1, 32'h10, 0, 0, 0, 0, 0, mkExp(1, 0, 32'h10, 0, 0, 0, 0, 0, 1, 0));
        addVec(1, 0, 32'h10, 0, 0, 0, 0, 0, z);
        addVec(1, 1, 32'h20, 0, 0, 0, 0, 32'hAAAA5555, mkExp(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        addVec(1, 1, 32'h20, 0, 0, 0, 0, 0, mkExp(1, 0, 32'h20, 0, 0, 0, 0, 0, 1, 0));
        addVec(1, 1, 32'h20, 0, 0, 0, 0, 0, mkExp(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        addVec(1, 1, 32'h20, 0, 0, 0, 0, 32'h0BADC0DE, mkExp(0, 0, 0, 0, 1, 32'h0BADC0DE, 0, 0, 0, 0));
        addVec(1, 0, 0, 0, 0, 0, 0, 0, z);
        // Reset during an access: outputs low, stale access discarded, fresh grant on release.
        addVec(1, 1, 32'h30, 0, 0, 0, 0, 0, mkExp(1, 0, 32'h30, 0, 0, 0, 0, 0, 1, 0));
        addVec(0, 1, 32'h30, 0, 0, 0, 0, 0, z);
        addVec(0, 1, 32'h30, 0, 0, 0, 0, 0, z);
        addVec(0, 1, 32'h30, 0, 0, 0, 0, 32'h77, z);
        addVec(1, 1, 32'h30, 0, 0, 0, 0, 32'h77, mkExp(1, 0, 32'h30, 0, 0, 0, 0, 0, 1, 0));
        addVec(1, 1, 32'h30, 0, 0, 0, 0, 0, mkExp(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        addVec(1, 1, 32'h30, 0, 0, 0, 0, 32'h44, mkExp(0, 0, 0, 0, 1, 32'h44, 0, 0, 0, 0));
        addVec(1, 0, 0, 0, 0, 0, 0, 0, z);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput($sformatf("vec%0d", i), observed(), vecs[i].expOut);
            @(posedge clk);
            #1;
        end

        // Both requests held: data wins four times, then fetch is forced through.
        v.rstN = 1; v.ifReq = 1; v.ifAddr = 32'h40; v.dReq = 1; v.dWe = 0;
        v.dAddr = 32'h300; v.dWdata = 0; v.memRdata = 32'h5A5A5A5A; v.expOut = '0;
        applyStimulus(v);
        for (int s = 0; s < 18; s++) begin
            logic            expEn;
            logic [W-1:0]    expAddr;
            logic            expIv;
            logic            expDv;
            expEn   = ((s % 3) == 0) && (s <= 15);
            expAddr = !expEn ? 32'h0 : (s == 12) ? 32'h40 : 32'h300;
            expIv   = (s == 14);
            expDv   = ((s % 3) == 2) && (s != 14);
            @(negedge clk);
            checkOutput($sformatf("starve%0d", s),
                        OUTW'({bus.mem_en, bus.mem_addr, bus.if_valid, bus.d_valid}),
                        OUTW'({expEn, expAddr, expIv, expDv}));
            @(posedge clk);
            #1;
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter W, default 32: address and data width.
REQ-002 Parameter LAT, default 2: fixed memory read latency in cycles, legal range 1..8.
REQ-003 Parameter STARVE_MAX, default 4: consecutive fetch denials before fetch is forced to win.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 if_req  input  1  fetch request; held with if_addr until if_valid.
REQ-007 if_addr  input  W  fetch address (the PC).
REQ-008 if_valid  output  1  one-cycle fetch completion strobe.
REQ-009 if_rdata  output  W  fetched instruction; qualified by if_valid.
REQ-010 d_req  input  1  data request; held with d_we, d_addr and d_wdata until d_valid.
REQ-011 d_we  input  1  1 = store, 0 = load.
REQ-012 d_addr  input  W  data address.
REQ-013 d_wdata  input  W  store data.
REQ-014 d_valid  output  1  one-cycle data completion strobe.
REQ-015 d_rdata  output  W  load data; qualified by d_valid.
REQ-016 mem_en  output  1  memory access issue strobe.
REQ-017 mem_we  output  1  memory write enable.
REQ-018 mem_addr  output  W  memory address.
REQ-019 mem_wdata  output  W  memory write data.
REQ-020 mem_rdata  input  W  memory read data, valid LAT cycles after mem_en.
REQ-021 stall_f  output  1  freeze the PC register and the fetch/decode pipeline register.
REQ-022 stall_m  output  1  freeze the memory stage.

Function
REQ-023 FSM states SHALL be IDLE, BUSY_I and BUSY_D. Only one access is outstanding at a time.
REQ-024 In IDLE, arbitration SHALL follow these rules:
- d_req alone: grant data.
- if_req alone: grant fetch.
- Both requests: grant data unless starve_cnt == STARVE_MAX, in which case grant fetch.
REQ-025 The grant cycle SHALL drive the memory and register the transaction:
- mem_en=1, with mem_addr, mem_we and mem_wdata taken from the winner.
- mem_we=0 and mem_wdata=0 for fetch.
- Next state is BUSY_I or BUSY_D, and lat_cnt is loaded with LAT-1.
REQ-026 Outside a grant cycle, mem_en, mem_we, mem_addr and mem_wdata SHALL be 0.
REQ-027 In a BUSY state, lat_cnt SHALL decrement each cycle. The completion cycle is the cycle with lat_cnt==0, which is exactly LAT cycles after grant. On the cycle after completion, the FSM returns to IDLE.
REQ-028 Completion cycle outputs:
- BUSY_I: if_valid=1 and if_rdata=mem_rdata.
- BUSY_D: d_valid=1; d_rdata=mem_rdata for loads and 0 for stores.
- All other cycles: valid=0 and rdata=0.
REQ-029 The earliest next grant SHALL be at grant+LAT+1, giving a throughput of one access per LAT+1 cycles.
REQ-030 starve_cnt (3 bits) SHALL update at each grant:
- Increments by 1 when data is granted while if_req=1.
- Clears to 0 when fetch is granted.
- Saturates at STARVE_MAX.
REQ-031 The stall outputs SHALL be stall_f = if_req & ~if_valid and stall_m = d_req & ~d_valid.
REQ-032 Abort: if the owning requester deasserts req during BUSY, a sticky abort flag SHALL set.
- The completion strobe is suppressed, even if req has been re-raised.
- The access still completes at memory, and stores still write.
- The flag clears on return to IDLE.
REQ-033 A request raised during BUSY SHALL wait for IDLE, and its address is sampled only at its grant cycle.
REQ-034 With LAT=1, the grant is followed by exactly one BUSY cycle, which is the completion cycle.

Reset
REQ-035 While rst=0, the block SHALL hold the following:
- State IDLE, lat_cnt=0, starve_cnt=0, abort flag=0.
- All outputs 0, including mem_en, stall_f and stall_m, regardless of request inputs.
REQ-036 Reset asserted mid-transaction SHALL discard the in-flight access: no valid strobe follows release.
REQ-037 The first grant after release SHALL occur on the first rising edge with rst=1.

Verification (LAT=2, STARVE_MAX=4; cycle 0 is the first cycle a request is visible)
REQ-038 Fetch only: if_req=1, if_addr=0x10, mem_rdata=0x00500093 at cycle 2 -> mem_en=1, mem_addr=0x10 at cycle 0; stall_f=1 at cycles 0-1; if_valid=1, if_rdata=0x00500093, stall_f=0 at cycle 2; next grant at cycle 3.
REQ-039 Simultaneous requests: if_req=1 (0x14) and d_req=1 (load 0x200) at cycle 0 -> data granted at cycle 0, d_valid at cycle 2; fetch granted at cycle 3, if_valid at cycle 5; starve_cnt=1 then 0.
REQ-040 Starvation: d_req and if_req held continuously -> data grants at cycles 0, 3, 6 and 9; fetch grant at cycle 12; data grant at cycle 15.
REQ-041 Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF -> mem_en=1, mem_we=1, mem_wdata=0xDEADBEEF at cycle 0; d_valid=1, d_rdata=0 at cycle 2.
REQ-042 Abort: fetch to 0x10 granted at cycle 0; if_req=0 at cycle 1; if_req=1, if_addr=0x20 from cycle 2 -> no if_valid at cycle 2; grant with mem_addr=0x20 at cycle 3; if_valid at cycle 5.
REQ-043 Reset mid-op: fetch granted at cycle 0, rst=0 during cycles 1-3, if_req held -> all outputs 0 during cycles 1-3; no if_valid from the stale access; fresh grant on the first cycle after release.
